// File: rtl/core_pkg.sv
// Shared definitions for the execute-stage multiply/divide unit.
// Holds the RV32M funct3 encodings, the sequencer states and result constants.
package core_pkg;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } muldiv_op_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CALC,
        ST_FIX
    } muldiv_state_t;

    localparam logic [31:0] DIV_ZERO_Q = 32'hFFFFFFFF;
    localparam logic [31:0] INT_MIN    = 32'h80000000;

endpackage

// File: rtl/core_muldiv_fixup.sv
// Sign restoration and result selection for the multiply/divide unit.
// Ports: op, operand sign flags, rs1 magnitude, raw product or {rem,quo},
//        divide-by-zero / overflow flags in; 32-bit result out.
module core_muldiv_fixup
    import core_pkg::*;
(
    input  muldiv_op_t  op,
    input  logic        neg1,
    input  logic        neg2,
    input  logic [31:0] mag1,
    input  logic [63:0] prod,
    input  logic        div_zero,
    input  logic        overflow,
    output logic [31:0] res
);

    logic [63:0] prod_s;
    logic [31:0] quo;
    logic [31:0] rem;
    logic [31:0] rs1;

    always_comb begin
        prod_s = (neg1 ^ neg2) ? -prod : prod;
        // Divider leaves the quotient in the low half, remainder in the high half
        quo    = (neg1 ^ neg2) ? -prod[31:0] : prod[31:0];
        rem    = neg1 ? -prod[63:32] : prod[63:32];
        // Divide by zero returns rs1 unchanged, rebuilt from its magnitude
        rs1    = neg1 ? -mag1 : mag1;
        res    = '0;
        unique case (op)
            OP_MUL:                       res = prod_s[31:0];
            OP_MULH, OP_MULHSU, OP_MULHU: res = prod_s[63:32];
            OP_DIV, OP_DIVU:
                res = div_zero ? DIV_ZERO_Q : (overflow ? INT_MIN : quo);
            OP_REM, OP_REMU:
                res = div_zero ? rs1 : (overflow ? 32'd0 : rem);
            default:                      res = '0;
        endcase
    end

endmodule

// File: rtl/core_muldiv.sv
// Iterative RV32M multiply/divide unit (shift-add multiply, restoring divide).
// Ports: clk, rst (sync, active-high), i_start/i_funct3/i_num1u/i_num2u request,
//        i_flush abort; o_busy stall, o_done one-cycle pulse, o_res result.
// Build option MULDIV_FAST_MUL_EN: single-cycle combinational multiply.
module core_muldiv #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_start,
    input  logic [2:0]      i_funct3,
    input  logic [XLEN-1:0] i_num1u,
    input  logic [XLEN-1:0] i_num2u,
    input  logic            i_flush,
    output logic            o_busy,
    output logic            o_done,
    output logic [XLEN-1:0] o_res
);
    import core_pkg::*;

    muldiv_state_t state, state_nxt;
    muldiv_op_t    op_q;
    logic          neg1_q, neg2_q, dz_q, ovf_q;
    logic [31:0]   mag1_q, mag2_q;
    logic [63:0]   acc_q;
    logic [4:0]    cnt_q;

    logic          is_div, sgn1, sgn2, neg1, neg2, dz, ovf, special, accept;
    logic [31:0]   mag1, mag2;

    always_comb begin
        is_div  = i_funct3[2];
        sgn2    = (i_funct3 == OP_MULH) || (is_div && !i_funct3[0]);
        sgn1    = sgn2 || (i_funct3 == OP_MULHSU);
        neg1    = sgn1 && i_num1u[31];
        neg2    = sgn2 && i_num2u[31];
        mag1    = neg1 ? -i_num1u : i_num1u;
        mag2    = neg2 ? -i_num2u : i_num2u;
        dz      = is_div && (i_num2u == '0);
        ovf     = is_div && sgn2 && (i_num1u == INT_MIN)
                  && (i_num2u == DIV_ZERO_Q);
        special = dz || ovf;
`ifdef MULDIV_FAST_MUL_EN
        special = special || !is_div;
`endif
    end

    assign accept = (state == ST_IDLE) && i_start && !i_flush;
    assign o_busy = (state != ST_IDLE);

    // One iteration: multiply adds rs1 magnitude into the high half and
    // shifts right; divide shifts {rem,dividend} left and trial-subtracts.
    logic [32:0] mul_sum, rem_sh;
    logic [31:0] rem_new;
    logic        ge;
    logic [63:0] step;

    always_comb begin
        mul_sum = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, mag1_q} : 33'd0);
        rem_sh  = acc_q[63:31];
        ge      = rem_sh >= {1'b0, mag2_q};
        rem_new = ge ? rem_sh[31:0] - mag2_q : rem_sh[31:0];
        step    = op_q[2] ? {rem_new, acc_q[30:0], ge}
                          : {mul_sum, acc_q[31:1]};
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: if (accept) state_nxt = special ? ST_FIX : ST_CALC;
            ST_CALC: if (cnt_q == 5'd31) state_nxt = ST_FIX;
            ST_FIX:  state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
        if (i_flush) state_nxt = ST_IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    logic [63:0] fix_prod;
    logic        fix_n1, fix_n2;
    logic [31:0] fix_res;

`ifdef MULDIV_FAST_MUL_EN
    logic [31:0]        raw1_q, raw2_q;
    logic signed [63:0] fast_prod;

    always_ff @(posedge clk) begin
        if (rst) begin
            raw1_q <= '0;
            raw2_q <= '0;
        end else if (accept) begin
            raw1_q <= i_num1u;
            raw2_q <= i_num2u;
        end
    end

    // Sign flag doubles as the 33rd bit, giving a 33x33 signed product
    assign fast_prod = 64'($signed({neg1_q, raw1_q}))
                     * 64'($signed({neg2_q, raw2_q}));
    assign fix_prod  = op_q[2] ? acc_q : fast_prod;
    assign fix_n1    = op_q[2] && neg1_q;
    assign fix_n2    = op_q[2] && neg2_q;
`else
    assign fix_prod  = acc_q;
    assign fix_n1    = neg1_q;
    assign fix_n2    = neg2_q;
`endif

    core_muldiv_fixup u_fixup (
        .op       (op_q),
        .neg1     (fix_n1),
        .neg2     (fix_n2),
        .mag1     (mag1_q),
        .prod     (fix_prod),
        .div_zero (dz_q),
        .overflow (ovf_q),
        .res      (fix_res)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            op_q   <= OP_MUL;
            neg1_q <= 1'b0;
            neg2_q <= 1'b0;
            dz_q   <= 1'b0;
            ovf_q  <= 1'b0;
            mag1_q <= '0;
            mag2_q <= '0;
            acc_q  <= '0;
            cnt_q  <= '0;
            o_done <= 1'b0;
            o_res  <= '0;
        end else begin
            o_done <= 1'b0;
            if (accept) begin
                op_q   <= muldiv_op_t'(i_funct3);
                neg1_q <= neg1;
                neg2_q <= neg2;
                dz_q   <= dz;
                ovf_q  <= ovf;
                mag1_q <= mag1;
                mag2_q <= mag2;
                acc_q  <= {32'd0, is_div ? mag1 : mag2};
                cnt_q  <= '0;
            end else if (!i_flush) begin
                if (state == ST_CALC) begin
                    acc_q <= step;
                    cnt_q <= cnt_q + 5'd1;
                end
                if (state == ST_FIX) begin
                    o_done <= 1'b1;
                    o_res  <= fix_res;
                end
            end
        end
    end

endmodule

// File: doc/core_muldiv.md
# core_muldiv

Iterative RV32M multiply/divide unit sitting beside the single-cycle integer ALU in the execute stage. It accepts one MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU operation at a time and sequences a radix-2 shift-add multiplier or a restoring divider over 32 cycles. It signals busy so the pipeline controller can stall. It also supports flush on branch/trap redirect.

## Interface
- `XLEN`, 32: operand and result width; only 32 is supported.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `i_start`  in  1  request; sampled only when the state is IDLE.
- `i_funct3`  in  3  RV32M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `i_num1u`, `i_num2u`  in  32  rs1 and rs2 values, raw bits.
- `i_flush`  in  1  abort any in-flight operation.
- `o_busy`  out  1  high while the state is not IDLE.
- `o_done`  out  1  one-cycle pulse when the result is valid.
- `o_res`  out  32  result; held from the done pulse until the next done pulse.

## Operation
- States and transitions:
  - IDLE → CALC on an accepted start.
  - IDLE → FIX directly on an accepted start for the special cases below.
  - CALC → FIX after iteration 31.
  - FIX → IDLE.
- Accept rule: `i_start` is accepted when state=IDLE and `i_flush`=0. It latches funct3, operand magnitudes, and the sign flags.
- Sign handling:
  - MULH and DIV/REM: both operands signed.
  - MULHSU: rs1 signed, rs2 unsigned.
  - Other ops: unsigned.
  - Magnitudes are taken as two's-complement absolute values.
- Multiply: 64-bit product register and 5-bit counter; one add-shift per CALC cycle. MUL returns the low 32 bits; the MULH variants return the high 32 bits after the sign fixup.
- Divide: restoring, one quotient bit per CALC cycle. The quotient is negated if the operand signs differ. The remainder takes the dividend's sign.
- Special cases (go IDLE→FIX, no CALC):
  - Divide by zero: DIV/DIVU → 0xFFFFFFFF; REM/REMU → rs1.
  - Overflow, DIV 0x80000000 / 0xFFFFFFFF: DIV → 0x80000000, REM → 0.
- Start while busy: ignored, with no side effect.
- Flush: state goes to IDLE at the next edge. No done pulse is produced and `o_res` is unchanged. Flush takes priority over a simultaneous start.
- Reset values: state IDLE, `o_busy`=0, `o_done`=0, `o_res`=0, counter 0.

## Timing
- Let E0 be the edge that accepts the start.
- Normal path:
  - CALC runs on edges E1..E32.
  - FIX registers `o_res` at E33.
  - `o_done`=1 in cycle E33–E34, so latency is 34 cycles.
- Special-case path: FIX at E1, `o_done` in cycle E1–E2, so latency is 2 cycles.
- `o_busy` is high from E0 through E33, and low in the done cycle.
- Back-to-back: a new start may be accepted at the edge ending the done cycle.
- `o_done` and `o_busy` are never high together.

## Configuration
- `MULDIV_FAST_MUL_EN` defined:
  - MUL-family ops take the IDLE→FIX path and use a single combinational 33×33 signed product registered at FIX.
  - Multiply latency is 2 cycles.
  - Divide is unchanged.
- Undefined: all multiplies are iterative with 34-cycle latency.

## Structure
- Shared package `core_pkg`:
  - funct3 encodings as an enum `muldiv_op_t`.
  - State enum `muldiv_state_t`.
  - Constants `DIV_ZERO_Q` = 32'hFFFFFFFF and `INT_MIN` = 32'h80000000.
- One sub-module, `core_muldiv_fixup`: combinational sign restoration and result selection. Its inputs are op, sign flags, the raw product or quotient/remainder, and the special-case flags.

## Test plan
- MULH 0xFFFFFFFF × 0xFFFFFFFF → `o_res`=0x00000000, done at cycle 34 after start; MUL of the same operands → 0x00000001.
- MULHSU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF; MULHU → 0xFFFFFFFE.
- DIV −7 / 2 → 0xFFFFFFFD; REM −7 / 2 → 0xFFFFFFFF.
- Special cases, each with done at 2 cycles and busy low in the done cycle:
  - DIVU 5 / 0 → 0xFFFFFFFF.
  - REM 5 / 0 → 5.
  - DIV 0x80000000 / 0xFFFFFFFF → 0x80000000.
- DIVU 100 / 7 started, `i_flush` at cycle 10 together with a new `i_start` → no done pulse, `o_busy` low next cycle, `o_res` retains its old value. A following REMU 100 / 7 → 2.
- Back-to-back: start a second op in the done cycle → accepted, `o_busy` high next cycle. A start while busy is ignored. `rst` mid-CALC → all outputs 0 next cycle.
